// File: rtl/dmem_responder.sv
// Word-organised data memory with byte-lane writes, fixed read latency and access counters.
// Read data is captured at the accepting edge and presented while the FSM sits in RESP.
module dmem_responder #(
  parameter int SCALE   = 12,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_oe,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_we,
  output logic [31:0] mem_rdata,
  output logic        mem_valid,
  output logic        mem_ready,
  output logic [31:0] cnt_read,
  output logic [31:0] cnt_write
);

  localparam int         DEPTH     = 1 << SCALE;
  localparam logic [3:0] WAIT_LOAD = 4'(LATENCY - 1);
  localparam logic       SINGLE    = (LATENCY == 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  we);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++)
      if (we[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    return merged;
  endfunction

  logic [31:0]      mem_q [DEPTH];
  logic [SCALE-1:0] idx;
  logic             unused_addr;

  state_t      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic        ready_q, ready_d;
  logic [31:0] rdata_p1;
  logic [31:0] cnt_read_q, cnt_write_q;
  logic        req, acc_rd, acc_wr;

  // Byte offset and bits above the store depth alias away.
  assign idx         = mem_addr[2 +: SCALE];
  assign unused_addr = ^{mem_addr[31:2+SCALE], mem_addr[1:0]};

  assign req    = |mem_oe;
  assign acc_rd = req & ~(|mem_we) & ready_q;
  assign acc_wr = req &  (|mem_we) & ready_q;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE: begin
        if (acc_rd) begin
          if (SINGLE) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            wcnt_d  = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (wcnt_q <= 4'd1) state_d = RESP;
        else                wcnt_d  = wcnt_q - 4'd1;
      end
      RESP: begin
        state_d = acc_rd ? RESP : IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Ready is registered from the next state so no request input reaches it combinationally.
    ready_d = (state_d == IDLE) || ((state_d == RESP) && SINGLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wcnt_q      <= 4'd0;
      ready_q     <= 1'b0;
      rdata_p1    <= 32'd0;
      cnt_read_q  <= 32'd0;
      cnt_write_q <= 32'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      ready_q <= ready_d;
      if (acc_rd) begin
        rdata_p1   <= mem_q[idx];
        cnt_read_q <= cnt_read_q + 32'd1;
      end
      if (acc_wr) cnt_write_q <= cnt_write_q + 32'd1;
    end
  end

  // Store is deliberately left out of reset so contents survive it.
  always_ff @(posedge clk) begin
    if (acc_wr) mem_q[idx] <= merge_lanes(mem_q[idx], mem_wdata, mem_we);
  end

  assign mem_rdata = rdata_p1;
  assign mem_valid = (state_q == RESP);
  assign mem_ready = ready_q;
  assign cnt_read  = cnt_read_q;
  assign cnt_write = cnt_write_q;

endmodule
